result_serializer: RTL and testbench

Downstream drain stage for the Ascon integrated wrapper. Pops 128-bit words from the wrapper's result FIFO and emits them as 32-bit beats on a valid/ready stream, most-significant word first. After the core signals `done`, it appends the 128-bit tag for AEAD modes and reports a one-cycle end-of-frame status.

---
 rtl/result_serializer.sv | 174 +++++++++++++++++
 tb/tb_result_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// Drains 128-bit result words as 32-bit MSW-first beats, then appends the AEAD tag and ends the frame.
// First beat 3 cycles after FIFO non-empty; out_ready low stalls SEND/TAG with payload held.
module result_serializer #(
  parameter int OUT_W = 32,
  parameter int BEATS = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [127:0]     result,
  input  logic             result_empty,
  output logic             result_rd_en,
  input  logic             done,
  input  logic [127:0]     tagout,
  input  logic             tag_valid,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_is_tag,
  output logic             frame_done,
  output logic             tag_ok,
  output logic             seq_err,
  output logic             busy
);
  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_POP, ST_CAP, ST_SEND, ST_TAG, ST_END} state_t;

  state_t          state_q, state_d;
  logic [127:0]    sh_q, sh_d;
  logic [127:0]    tag_q, tag_d;
  logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            hash_q, hash_d;
  logic            in_frame_q, in_frame_d;
  logic            tag_ok_q, tag_ok_d;
  logic            done_seen_q, done_seen_d;
  logic            armed_q, armed_d;
  logic            seq_err_q, seq_err_d;
  logic            rd_en_q, rd_en_d;
  logic            out_valid_q, out_valid_d;
  logic            out_is_tag_q, out_is_tag_d;
  logic            frame_done_q, frame_done_d;
  logic            busy_q, busy_d;
  logic            beat_fire, last_beat, hash_eff;
  logic [1:0]      unused_mode;

  assign unused_mode = mode[1:0];
  assign beat_fire   = out_valid_q & out_ready;
  assign last_beat   = (beat_cnt_q == LAST_BEAT);
  // Before the first pop of a frame the mode has not been latched yet.
  assign hash_eff    = in_frame_q ? hash_q : mode[2];

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    tag_d       = tag_q;
    beat_cnt_d  = beat_cnt_q;
    hash_d      = hash_q;
    in_frame_d  = in_frame_q;
    tag_ok_d    = tag_ok_q;
    done_seen_d = done_seen_q;
    seq_err_d   = seq_err_q;

    case (state_q)
      ST_IDLE: begin
        if (!result_empty)  state_d = ST_POP;
        else if (armed_q)   state_d = hash_eff ? ST_END : ST_TAG;
      end
      ST_POP: begin
        state_d = ST_CAP;
        if (!in_frame_q) begin
          in_frame_d = 1'b1;
          hash_d     = mode[2];
          if (!done_seen_q) tag_ok_d = 1'b0;
        end
      end
      ST_CAP: begin
        sh_d       = result;
        beat_cnt_d = '0;
        state_d    = ST_SEND;
      end
      ST_SEND, ST_TAG: begin
        if (beat_fire) begin
          sh_d       = {sh_q[127-OUT_W:0], {OUT_W{1'b0}}};
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            if (state_q == ST_TAG)  state_d = ST_END;
            else if (!result_empty) state_d = ST_POP;
            else if (armed_q)       state_d = hash_eff ? ST_END : ST_TAG;
            else                    state_d = ST_IDLE;
          end
        end
      end
      ST_END: begin
        state_d     = ST_IDLE;
        done_seen_d = 1'b0;
        in_frame_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d == ST_TAG && state_q != ST_TAG) begin
      sh_d       = tag_q;
      beat_cnt_d = '0;
    end

    // A second done before retirement is flagged and otherwise ignored.
    if (done) begin
      if (done_seen_q) begin
        seq_err_d = 1'b1;
      end else begin
        done_seen_d = 1'b1;
        tag_d       = tagout;
        tag_ok_d    = tag_valid;
      end
    end

    armed_d      = done_seen_q & done_seen_d;
    rd_en_d      = (state_d == ST_POP);
    out_valid_d  = (state_d == ST_SEND) || (state_d == ST_TAG);
    out_is_tag_d = (state_d == ST_TAG);
    frame_done_d = (state_d == ST_END);
    busy_d       = (state_d != ST_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      sh_q         <= '0;
      tag_q        <= '0;
      beat_cnt_q   <= '0;
      hash_q       <= 1'b0;
      in_frame_q   <= 1'b0;
      tag_ok_q     <= 1'b0;
      done_seen_q  <= 1'b0;
      armed_q      <= 1'b0;
      seq_err_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      out_valid_q  <= 1'b0;
      out_is_tag_q <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      tag_q        <= tag_d;
      beat_cnt_q   <= beat_cnt_d;
      hash_q       <= hash_d;
      in_frame_q   <= in_frame_d;
      tag_ok_q     <= tag_ok_d;
      done_seen_q  <= done_seen_d;
      armed_q      <= armed_d;
      seq_err_q    <= seq_err_d;
      rd_en_q      <= rd_en_d;
      out_valid_q  <= out_valid_d;
      out_is_tag_q <= out_is_tag_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign result_rd_en = rd_en_q;
  assign out_data     = sh_q[127 -: OUT_W];
  assign out_valid    = out_valid_q;
  assign out_is_tag   = out_is_tag_q;
  assign out_last     = ((state_q == ST_SEND) && last_beat && hash_q && result_empty && armed_q) ||
                        ((state_q == ST_TAG) && last_beat);
  assign frame_done   = frame_done_q;
  assign tag_ok       = tag_ok_q;
  assign seq_err      = seq_err_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_result_serializer.sv
// Directed and randomized frames against a beat-queue reference model and a behavioural result FIFO.
module tb_result_serializer;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   mode = '0;
  logic [127:0] result = '0;
  logic         result_empty = 1'b1;
  logic         result_rd_en;
  logic         done = 1'b0;
  logic [127:0] tagout = '0;
  logic         tag_valid = 1'b0;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_last;
  logic         out_is_tag;
  logic         frame_done;
  logic         tag_ok;
  logic         seq_err;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed { logic [31:0] d; logic last; logic tag; } beat_t;
  beat_t        exp_q[$];
  logic [127:0] words[$];
  logic [127:0] fifo[$];
  logic         wr_en = 1'b0;
  logic [127:0] wr_data = '0;
  logic         exp_tag_ok = 1'b0;
  logic         exp_seq_err = 1'b0;

  result_serializer #(.OUT_W(32), .BEATS(4)) dut (
    .clock(clock), .reset(reset), .mode(mode), .result(result),
    .result_empty(result_empty), .result_rd_en(result_rd_en), .done(done),
    .tagout(tagout), .tag_valid(tag_valid), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_is_tag(out_is_tag), .frame_done(frame_done), .tag_ok(tag_ok),
    .seq_err(seq_err), .busy(busy)
  );

  always #5 clock = ~clock;

  // Result FIFO: registered read data, empty flag updates the cycle after a push/pop.
  always @(posedge clock) begin
    if (reset) begin
      fifo.delete();
      result_empty <= 1'b1;
    end else begin
      if (result_rd_en && fifo.size() > 0) result <= fifo.pop_front();
      if (wr_en) fifo.push_back(wr_data);
      result_empty <= (fifo.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check_idle_outputs(input string ctx);
    check({ctx, "_rd_en"},      result_rd_en, 0);
    check({ctx, "_out_data"},   out_data, 0);
    check({ctx, "_out_valid"},  out_valid, 0);
    check({ctx, "_out_last"},   out_last, 0);
    check({ctx, "_out_is_tag"}, out_is_tag, 0);
    check({ctx, "_frame_done"}, frame_done, 0);
    check({ctx, "_tag_ok"},     tag_ok, 0);
    check({ctx, "_seq_err"},    seq_err, 0);
    check({ctx, "_busy"},       busy, 0);
  endtask

  // Pushes words[] one per cycle, pulses done dly cycles after the last push, and checks every beat.
  task automatic run_frame(input bit hash, input int nw, input int dly, input bit bp,
                           input bit dbl, input logic [127:0] tg, input bit tv);
    beat_t        e;
    logic [127:0] w;
    logic [127:0] tg2;
    logic [31:0]  pd;
    bit           fd_exp, got_fd, prev_stall, prev_rd, pl, pt, second;
    int           first_done;
    fd_exp = 0; got_fd = 0; prev_stall = 0; prev_rd = 0; pd = '0; pl = 0; pt = 0;
    tg2 = rnd128();
    exp_q.delete();
    for (int i = 0; i < nw; i++) begin
      w = words[i];
      for (int b = 0; b < 4; b++) exp_q.push_back('{w[127-32*b -: 32], hash && i == nw-1 && b == 3, 1'b0});
    end
    if (!hash)
      for (int b = 0; b < 4; b++) exp_q.push_back('{tg[127-32*b -: 32], b == 3, 1'b1});
    exp_tag_ok = tv;
    if (dbl) exp_seq_err = 1'b1;
    mode = {hash, 2'($urandom)};
    first_done = nw - 1 + dly;

    for (int cyc = 0; cyc < 400 && !got_fd; cyc++) begin
      @(negedge clock);
      if (prev_stall) begin
        check("stall_valid",  out_valid, 1);
        check("stall_data",   out_data, pd);
        check("stall_last",   out_last, pl);
        check("stall_is_tag", out_is_tag, pt);
      end
      check("frame_done_timing", frame_done, fd_exp);
      got_fd = (frame_done === 1'b1);
      if (result_rd_en) begin
        check("rd_en_while_empty", result_empty, 0);
        check("rd_en_back_to_back", prev_rd, 0);
      end
      prev_rd = result_rd_en;

      out_ready = bp ? 1'($urandom) : 1'b1;
      wr_en     = (cyc < nw);
      wr_data   = (cyc < nw) ? words[cyc] : '0;
      second    = dbl && (cyc == first_done + 2);
      done      = (cyc == first_done) || second;
      tagout    = second ? tg2 : tg;
      tag_valid = second ? ~tv : tv;

      fd_exp = 0;
      if (out_valid && out_ready) begin
        check("beat_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("beat_data",   out_data, e.d);
          check("beat_last",   out_last, e.last);
          check("beat_is_tag", out_is_tag, e.tag);
          fd_exp = e.last;
        end
      end
      prev_stall = out_valid && !out_ready;
      pd = out_data; pl = out_last; pt = out_is_tag;
    end
    wr_en = 0; done = 0; out_ready = 1;
    check("frame_done_seen", got_fd, 1);
    check("beats_left", exp_q.size(), 0);
    @(negedge clock);
    check("post_busy", busy, 0);
    check("post_frame_done", frame_done, 0);
    check("post_tag_ok", tag_ok, exp_tag_ok);
    check("post_seq_err", seq_err, exp_seq_err);
  endtask

  initial begin
    logic [127:0] w;
    bit           seen, h;
    int           nw;

    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 0;
    out_ready = 1;
    @(negedge clock);

    words = '{128'h00112233_44556677_8899AABB_CCDDEEFF};
    run_frame(1, 1, 0, 0, 0, rnd128(), 0);

    words = '{rnd128(), rnd128()};
    run_frame(0, 2, 3, 0, 0, 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE, 1);

    words = '{rnd128(), rnd128(), rnd128()};
    run_frame(1, 3, 0, 1, 0, rnd128(), 1);

    words = '{rnd128()};
    run_frame(0, 1, 0, 0, 0, rnd128(), 0);

    words = '{rnd128(), rnd128()};
    run_frame(0, 2, 0, 0, 1, rnd128(), 1);

    for (int k = 0; k < 8; k++) begin
      h  = 1'($urandom);
      nw = 1 + int'($urandom_range(0, 2));
      words.delete();
      for (int i = 0; i < nw; i++) words.push_back(rnd128());
      run_frame(h, nw, h ? 0 : int'($urandom_range(0, 8)), 1'($urandom), 0, rnd128(), 1'($urandom));
    end

    // Reset in the middle of a data word, with seq_err already set.
    w = rnd128();
    mode = 3'b001;
    wr_en = 1; wr_data = w; done = 1; tagout = rnd128(); tag_valid = 1;
    @(negedge clock);
    wr_en = 0; done = 1;
    @(negedge clock);
    done = 0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      seen = (out_valid === 1'b1);
    end
    check("rst_first_beat_seen", seen, 1);
    @(negedge clock);
    check("rst_beat1_data", out_data, w[95:64]);
    check("rst_seq_err_set", seq_err, 1);
    reset = 1;
    @(negedge clock);
    check_idle_outputs("midreset");
    reset = 0;
    exp_seq_err = 0;
    exp_tag_ok = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check("midreset_no_frame_done", frame_done, 0);
      check("midreset_idle", busy, 0);
    end

    words = '{rnd128()};
    run_frame(0, 1, 2, 1, 0, rnd128(), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
